piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per word; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  WIDTH  parallel word to transmit.
REQ-005 Port: load_valid  input  1  din is valid and requests transmission.
REQ-006 Port: load_ready  output  1  block accepts din on this cycle.
REQ-007 Port: sout  output  1  serial data bit.
REQ-008 Port: sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 Port: busy  output  1  frame in progress.
REQ-010 Port: done  output  1  one-cycle pulse coincident with the last frame bit.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; din is captured into an internal WIDTH-bit shift register.
REQ-013 load_ready SHALL be 1 in IDLE, and in SHIFT only during the last frame bit; otherwise it is 0.
REQ-014 Accepting a word in IDLE SHALL move the FSM to SHIFT; the first bit appears on sout in the cycle after the accepting edge (latency 1).
REQ-015 Bit order SHALL be MSB first (din[WIDTH-1] first, din[0] last), so that a serial-in/parallel-out shifter loading at bit 0 reconstructs the word after WIDTH shifts.
REQ-016 In SHIFT, each rising edge SHALL advance one bit; a down-counter of width clog2(WIDTH+1) tracks the remaining bits.
REQ-017 sout_valid and busy SHALL be 1 for every frame-bit cycle and 0 in IDLE.
REQ-018 sout SHALL be 0 whenever sout_valid is 0.
REQ-019 done SHALL be 1 only during the last frame bit.
REQ-020 On the last frame bit, if a word is accepted, the next cycle SHALL carry the new word's first bit, with no idle gap; otherwise the FSM returns to IDLE.
REQ-021 load_valid while load_ready is 0 SHALL be ignored; din is not sampled and the current frame is unaffected.
REQ-022 Changes on din during SHIFT SHALL NOT affect the transmitted frame.

Reset
REQ-023 Asserting rst_n low SHALL immediately force state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, busy 0, done 0, and load_ready 1 after the reset is released.
REQ-024 Reset asserted mid-frame SHALL abort the frame; the partial word is discarded and not resumed.
REQ-025 On the first rising edge after deassertion, a word SHALL be accepted if load_valid is 1.

Configuration
REQ-026 Macro PISO_PARITY_EN, when defined, SHALL append one even-parity bit (XOR of all WIDTH data bits) after din[0]; the frame is WIDTH+1 bits, and done and load_ready move to the parity-bit cycle.
REQ-027 Without PISO_PARITY_EN, the frame SHALL be exactly WIDTH bits and no parity logic is present.

Verification
REQ-028 WIDTH=8, load 0xA5 once -> sout=1,0,1,0,0,1,0,1 on cycles 1..8 after acceptance; done on cycle 8; busy low on cycle 9.
REQ-029 Back-to-back: load 0x3C, then 0xC3 held valid -> 16 consecutive valid bits 00111100 11000011, load_ready high only on cycles 0 and 8, no gap.
REQ-030 Reset mid-frame: load 0xFF, drive rst_n low after 3 bits -> all outputs 0 at once; after release, load 0x01 -> frame 00000001 transmits cleanly.
REQ-031 load_valid=1 with 0x55 during a 0xF0 frame -> 0xF0 transmits unchanged; 0x55 accepted only on the last-bit cycle.
REQ-032 PISO_PARITY_EN defined: load 0x07 -> sout=0,0,0,0,0,1,1,1,1 (parity 1); done on bit 9.
REQ-033 Loopback: connect sout into an 8-bit serial-in shifter clocked only when sout_valid is 1 -> the shifter holds the loaded word after done, for 0x00, 0xFF, and 0x5A.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer, MSB first, with ready/valid load handshake.
// Define PISO_PARITY_EN to append an even-parity bit after din[0].
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [FRAME-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;

    function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef PISO_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    // cnt holds the number of frame bits still to present, including the current one
    assign last       = (state == SHIFT) && (cnt == CNT_W'(1));
    assign load_ready = rst_n && ((state == IDLE) || last);
    assign accept     = load_valid && load_ready;
    assign sout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign done       = last;
    assign sout       = (state == SHIFT) && sreg[FRAME-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            sreg  <= frame_of(din);
            cnt   <= CNT_W'(FRAME);
        end else if (state == SHIFT) begin
            if (last) begin
                state <= IDLE;
                sreg  <= '0;
                cnt   <= '0;
            end else begin
                sreg  <= {sreg[FRAME-2:0], 1'b0};
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random traffic
// against a bit-queue reference model of the serial frame.
module tb_piso_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             load_valid = 1'b0;
    logic             load_ready, sout, sout_valid, busy, done;

    int errors = 0;
    int checks = 0;

    bit q[$];                 // bits still to appear on sout, current bit at front
    logic [FRAME-1:0] lb = '0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Loopback receiver: serial-in shifter loading at bit 0
    always @(posedge clk) if (sout_valid) lb <= {lb[FRAME-2:0], sout};

    function automatic logic [4:0] obs();
        return {sout, sout_valid, busy, done, load_ready};
    endfunction

    // Expected {sout, sout_valid, busy, done, load_ready} from the model
    function automatic logic [4:0] exp_outs();
        if (q.size() == 0) return 5'b00001;
        return {q[0], 1'b1, 1'b1, q.size() == 1, q.size() == 1};
    endfunction

    // Model of one rising edge given the inputs presented in this cycle
    task automatic model_edge(input logic lv, input logic [WIDTH-1:0] d);
        bit ready;
        bit par;
        ready = (q.size() <= 1);
        if (q.size() > 0) void'(q.pop_front());
        if (lv && ready) begin
            par = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                q.push_back(((d >> i) & 1) != 0);
                par ^= ((d >> i) & 1) != 0;
            end
`ifdef PISO_PARITY_EN
            q.push_back(par);
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        if (obs() !== 5'b00000) begin
            errors++; $display("FAIL reset_hold outs=%b exp=%b", obs(), 5'b00000);
        end
        checks++;
        tick(); tick();
        rst_n = 1'b1;
        q.delete();
        #1;
        if (obs() !== 5'b00001) begin
            errors++; $display("FAIL reset_release outs=%b exp=%b", obs(), 5'b00001);
        end
        checks++;
    endtask

    task automatic test_single();
        logic lv;
        for (int c = 0; c <= FRAME + 1; c++) begin
            lv  = (c == 0);
            din = 8'hA5;
            load_valid = lv;
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL single_a5 cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            model_edge(lv, din);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w;
        int rdy_hi;
        rdy_hi = 0;
        for (int c = 0; c <= 2 * FRAME + 1; c++) begin
            w = (c == 0) ? 8'h3C : 8'hC3;
            load_valid = (c <= FRAME);
            din = w;
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL b2b cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            if (load_ready && (c <= FRAME)) rdy_hi++;
            model_edge(load_valid, din);
            tick();
        end
        load_valid = 1'b0;
        if (rdy_hi !== 2) begin
            errors++; $display("FAIL b2b_ready_count got=%0d exp=2", rdy_hi);
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        din = 8'hFF; load_valid = 1'b1;
        #1;
        model_edge(1'b1, din);
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            model_edge(1'b0, din);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        if (obs() !== 5'b00000) begin
            errors++; $display("FAIL midframe_abort outs=%b exp=%b", obs(), 5'b00000);
        end
        checks++;
        tick();
        rst_n = 1'b1;
        q.delete();
        for (int c = 0; c <= FRAME + 1; c++) begin
            load_valid = (c == 0);
            din = 8'h01;
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL after_reset cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            model_edge(load_valid, din);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic test_ignore_load();
        int acc_cyc;
        acc_cyc = -1;
        for (int c = 0; c <= 2 * FRAME + 1; c++) begin
            load_valid = (c <= FRAME);
            din = (c == 0) ? 8'hF0 : 8'h55;
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL ignore cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            if (c > 0 && load_valid && load_ready && acc_cyc < 0) acc_cyc = c;
            model_edge(load_valid, din);
            tick();
        end
        load_valid = 1'b0;
        if (acc_cyc !== FRAME) begin
            errors++; $display("FAIL ignore_accept_cycle got=%0d exp=%0d", acc_cyc, FRAME);
        end
        checks++;
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [FRAME-1:0] bits;
        bits = '0;
        for (int c = 0; c <= FRAME + 1; c++) begin
            load_valid = (c == 0);
            din = 8'h07;
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL parity cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            if (c >= 1 && c <= FRAME) bits = {bits[FRAME-2:0], sout};
            model_edge(load_valid, din);
            tick();
        end
        load_valid = 1'b0;
        if (bits !== 9'b000001111) begin
            errors++; $display("FAIL parity_frame got=%b exp=%b", bits, 9'b000001111);
        end
        checks++;
    endtask
`endif

    task automatic test_loopback();
        logic [WIDTH-1:0] words [3];
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            lb = {FRAME{~words[k][0]}};
            for (int c = 0; c <= FRAME; c++) begin
                load_valid = (c == 0);
                din = words[k];
                #1;
                model_edge(load_valid, din);
                tick();
            end
            load_valid = 1'b0;
            if (lb[FRAME-1 -: WIDTH] !== words[k]) begin
                errors++; $display("FAIL loopback got=%h exp=%h", lb[FRAME-1 -: WIDTH], words[k]);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            load_valid = ($urandom_range(0, 9) < 6);
            din = WIDTH'($urandom);
            #1;
            if (obs() !== exp_outs()) begin
                errors++; $display("FAIL random cyc=%0d outs=%b exp=%b", c, obs(), exp_outs());
            end
            checks++;
            model_edge(load_valid, din);
            tick();
        end
        load_valid = 1'b0;
        for (int c = 0; c <= FRAME; c++) begin
            #1;
            model_edge(1'b0, din);
            tick();
        end
        if (obs() !== 5'b00001) begin
            errors++; $display("FAIL random_drain outs=%b exp=%b", obs(), 5'b00001);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_load();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_loopback();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
